// File: rtl/game_mode_ctrl.sv
// game_mode_ctrl
// Arbitrates a single set of board resources (two buttons, 16 LEDs, one
// 4-digit 7-segment display) between up to four game-mode blocks.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset (0 = reset)
//   btn_mode   raw mode-select button (asynchronous to clk, bouncy)
//   btn_go     raw go/stop button (asynchronous to clk, bouncy)
//   mode_led   LED vector of mode k at bits [16k+15:16k]
//   mode_seg   seg_data of mode k at bits [16k+15:16k]
//   active     one-hot enable per mode; a mode clears itself while its bit is 0
//   go_pulse   one-cycle go/stop strobe per mode
//   led        board LEDs
//   seg_data   four nibbles for the 7-segment driver
//   cur_mode   currently selected mode index
//
// Operation: buttons are synchronized and debounced, and their rising edges
// become one-cycle press events. In IDLE the mode button cycles the selection
// and the go button starts the selected mode after a guard interval. In RUN the
// selected mode owns the LEDs/display and receives go strobes; a mode press
// selects the next mode and passes through the guard interval again, so the
// old mode is fully disabled before the new one is enabled.
module game_mode_ctrl #(
    parameter int NUM_MODES       = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int GUARD_CYCLES    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn_mode,
    input  logic                     btn_go,
    input  logic [16*NUM_MODES-1:0]  mode_led,
    input  logic [16*NUM_MODES-1:0]  mode_seg,
    output logic [NUM_MODES-1:0]     active,
    output logic [NUM_MODES-1:0]     go_pulse,
    output logic [15:0]              led,
    output logic [15:0]              seg_data,
    output logic [1:0]               cur_mode
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_ONE  = DW'(1);
    localparam logic [GW-1:0] G_LOAD  = GW'(GUARD_CYCLES - 1);
    localparam logic [GW-1:0] G_ONE   = GW'(1);

    // Button lanes: bit 0 = mode button, bit 1 = go button.
    localparam int B_MODE = 0;
    localparam int B_GO   = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GUARD = 2'b01,
        S_RUN   = 2'b10
    } state_t;

    // One-hot decode of a 2-bit mode index onto NUM_MODES enables.
    function automatic logic [NUM_MODES-1:0] mode_onehot(input logic [1:0] m);
        logic [NUM_MODES-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (m == 2'(k)) begin
                v[k] = 1'b1;
            end else begin
                v[k] = 1'b0;
            end
        end
        return v;
    endfunction

    // Next mode index, wrapping at NUM_MODES-1.
    function automatic logic [1:0] mode_next(input logic [1:0] m);
        if (m == 2'(NUM_MODES - 1)) begin
            return 2'b00;
        end else begin
            return m + 2'b01;
        end
    endfunction

    // Display pattern while no mode owns the board: "FF0m".
    function automatic logic [15:0] seg_idle(input logic [1:0] m);
        return {8'hFF, 4'h0, 2'b00, m};
    endfunction

    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    db_lvl_q;
    logic [1:0]    db_lvl_d;
    logic [1:0]    db_prev_q;
    logic [1:0]    armed_q;
    logic [1:0]    armed_d;
    logic [1:0]    press_s;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];

    state_t               state_q;
    state_t               state_d;
    logic [1:0]           mode_q;
    logic [1:0]           mode_d;
    logic [GW-1:0]        gcnt_q;
    logic [GW-1:0]        gcnt_d;
    logic [NUM_MODES-1:0] active_q;
    logic [NUM_MODES-1:0] active_d;
    logic [NUM_MODES-1:0] go_q;
    logic [NUM_MODES-1:0] go_d;
    logic [15:0]          led_q;
    logic [15:0]          led_d;
    logic [15:0]          seg_q;
    logic [15:0]          seg_d;
    logic [15:0]          led_sel_s;
    logic [15:0]          seg_sel_s;

    // Two-flop synchronizer for both buttons.
    // Reset value 1 looks like "held" so that a button must be seen released
    // after reset before it can arm (see armed_d below).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= {btn_go, btn_mode};
            sync2_q <= sync1_q;
        end
    end

    // Debounce counters, debounced levels, edge history and arming flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_lvl_q    <= 2'b00;
            db_prev_q   <= 2'b00;
            armed_q     <= 2'b00;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            db_lvl_q    <= db_lvl_d;
            db_prev_q   <= db_lvl_q;
            armed_q     <= armed_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
        end
    end

    // Debounce next-state and press-event decode.
    // A button only arms once its synchronized level has been seen low with
    // the debounced level also low; a button held through reset therefore
    // yields no press until it is released and pressed again.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_lvl_d[i] = db_lvl_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_lvl_d[i] = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
                end
            end else begin
                db_cnt_d[i] = '0;
            end
            armed_d[i] = armed_q[i] | (~sync2_q[i] & ~db_lvl_d[i]);
            press_s[i] = armed_q[i] & db_lvl_q[i] & ~db_prev_q[i];
        end
    end

    // Select the LED / display slice of the current mode.
    always_comb begin
        led_sel_s = 16'h0000;
        seg_sel_s = 16'h0000;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (mode_q == 2'(k)) begin
                led_sel_s = mode_led[16*k +: 16];
                seg_sel_s = mode_seg[16*k +: 16];
            end else begin
                led_sel_s = led_sel_s;
                seg_sel_s = seg_sel_s;
            end
        end
    end

    // Mode FSM next-state logic; a mode press always wins over a go press.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        gcnt_d  = gcnt_q;
        go_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (press_s[B_MODE]) begin
                    mode_d = mode_next(mode_q);
                end else if (press_s[B_GO]) begin
                    state_d = S_GUARD;
                    gcnt_d  = G_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GUARD: begin
                // Presses are ignored here; the counter alone decides exit.
                if (gcnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    gcnt_d = gcnt_q - G_ONE;
                end
            end
            S_RUN: begin
                if (press_s[B_MODE]) begin
                    mode_d  = mode_next(mode_q);
                    state_d = S_GUARD;
                    gcnt_d  = G_LOAD;
                end else if (press_s[B_GO]) begin
                    go_d = mode_onehot(mode_q);
                end else begin
                    go_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                mode_d  = 2'b00;
                gcnt_d  = '0;
            end
        endcase
    end

    // Output next-values. Enables follow the next state so that active drops
    // on the same edge that leaves RUN. The board slice is only forwarded
    // while RUN persists across the edge, giving one cycle of latency after
    // entry and blanking as soon as a switch begins.
    always_comb begin
        if (state_d == S_RUN) begin
            active_d = mode_onehot(mode_d);
        end else begin
            active_d = '0;
        end
        if ((state_q == S_RUN) && (state_d == S_RUN)) begin
            led_d = led_sel_s;
            seg_d = seg_sel_s;
        end else begin
            led_d = 16'h0000;
            seg_d = seg_idle(mode_d);
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mode_q   <= 2'b00;
            gcnt_q   <= '0;
            active_q <= '0;
            go_q     <= '0;
            led_q    <= 16'h0000;
            seg_q    <= 16'hFF00;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            gcnt_q   <= gcnt_d;
            active_q <= active_d;
            go_q     <= go_d;
            led_q    <= led_d;
            seg_q    <= seg_d;
        end
    end

    assign active   = active_q;
    assign go_pulse = go_q;
    assign led      = led_q;
    assign seg_data = seg_q;
    assign cur_mode = mode_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Self-checking bench for game_mode_ctrl: directed scenarios followed by
// randomized button/LED traffic, every cycle compared against a behavioural
// model of the mode controller.
module tb_game_mode_ctrl;

    localparam int N = 4;
    localparam int D = 3;
    localparam int G = 4;
    localparam int PH_IDLE  = 0;
    localparam int PH_GUARD = 1;
    localparam int PH_RUN   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          btn_mode = 1'b0;
    logic          btn_go = 1'b0;
    logic [63:0]   mode_led = 64'h0;
    logic [63:0]   mode_seg = 64'h0;
    logic [3:0]    active;
    logic [3:0]    go_pulse;
    logic [15:0]   led;
    logic [15:0]   seg_data;
    logic [1:0]    cur_mode;

    game_mode_ctrl #(
        .NUM_MODES(N),
        .DEBOUNCE_CYCLES(D),
        .GUARD_CYCLES(G)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_mode(btn_mode),
        .btn_go(btn_go),
        .mode_led(mode_led),
        .mode_seg(mode_seg),
        .active(active),
        .go_pulse(go_pulse),
        .led(led),
        .seg_data(seg_data),
        .cur_mode(cur_mode)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          phase;
    int          mode;
    int          left;
    bit          raw1 [2];     // raw level sampled one edge ago
    bit          raw2 [2];     // raw level sampled two edges ago
    logic [15:0] hist [2];     // synchronized samples, newest in bit 0
    int          nh   [2];
    bit          deb  [2];
    bit          armed[2];
    bit          press[2];
    logic [3:0]  e_active;
    logic [3:0]  e_go;
    logic [15:0] e_led;
    logic [15:0] e_seg;

    task automatic model_reset();
        phase = PH_IDLE; mode = 0; left = 0;
        for (int b = 0; b < 2; b++) begin
            raw1[b] = 1'b1; raw2[b] = 1'b1; hist[b] = 16'h0; nh[b] = 0;
            deb[b] = 1'b0; armed[b] = 1'b0; press[b] = 1'b0;
        end
        e_active = 4'h0; e_go = 4'h0; e_led = 16'h0; e_seg = 16'hFF00;
    endtask

    task automatic model_step();
        int  old_phase;
        bit  raw;
        bit  s;
        bit  old;
        bit  flip;
        old_phase = phase;
        e_go = 4'h0;
        if (phase == PH_IDLE) begin
            if (press[0]) mode = (mode + 1) % N;
            else if (press[1]) begin phase = PH_GUARD; left = G - 1; end
        end else if (phase == PH_GUARD) begin
            if (left == 0) phase = PH_RUN;
            else left = left - 1;
        end else begin
            if (press[0]) begin mode = (mode + 1) % N; phase = PH_GUARD; left = G - 1; end
            else if (press[1]) e_go = 4'(1 << mode);
        end
        e_active = (phase == PH_RUN) ? 4'(1 << mode) : 4'h0;
        if (old_phase == PH_RUN && phase == PH_RUN) begin
            e_led = mode_led[16*mode +: 16];
            e_seg = mode_seg[16*mode +: 16];
        end else begin
            e_led = 16'h0;
            e_seg = 16'hFF00 | 16'(mode);
        end
        for (int b = 0; b < 2; b++) begin
            raw = (b == 0) ? btn_mode : btn_go;
            s = raw2[b];
            raw2[b] = raw1[b];
            raw1[b] = raw;
            hist[b] = {hist[b][14:0], s};
            if (nh[b] < 16) nh[b]++;
            old = deb[b];
            flip = (nh[b] >= D);
            for (int i = 0; i < D; i++) if (hist[b][i] == old) flip = 1'b0;
            if (flip) deb[b] = s;
            press[b] = armed[b] && deb[b] && !old;
            if (!s && !deb[b]) armed[b] = 1'b1;
        end
    endtask

    // ---------------- cycle driver and monitors ----------------
    int          go_count = 0;
    logic [3:0]  last_go = 4'h0;
    logic [3:0]  prev_active = 4'h0;
    bit          gap_armed = 1'b0;
    int          gap = 0;

    task automatic cycle();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        chk("active", 32'(active), 32'(e_active));
        chk("go_pulse", 32'(go_pulse), 32'(e_go));
        chk("led", 32'(led), 32'(e_led));
        chk("seg_data", 32'(seg_data), 32'(e_seg));
        chk("cur_mode", 32'(cur_mode), 32'(mode));
        chk("active_onehot0", {31'b0, $onehot0(active)}, 32'd1);
        chk("go_onehot0", {31'b0, $onehot0(go_pulse)}, 32'd1);
        chk("go_within_active", 32'(go_pulse & ~active), 32'd0);
        if (go_pulse != 4'h0) begin
            go_count++;
            last_go = go_pulse;
        end
        if (active != 4'h0) begin
            if (gap_armed) chk("guard_gap", 32'(gap), 32'(G));
            gap_armed = 1'b0;
        end else if (prev_active != 4'h0) begin
            gap_armed = 1'b1;
            gap = 1;
        end else if (gap_armed) begin
            gap++;
        end
        prev_active = active;
    endtask

    // Assert reset (asynchronously, between edges) for n clocks.
    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_go", 32'(go_pulse), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_seg", 32'(seg_data), 32'hFF00);
        chk("rst_mode", 32'(cur_mode), 32'd0);
        model_reset();
        gap_armed = 1'b0;
        prev_active = 4'h0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_hold_active", 32'(active), 32'd0);
            chk("rst_hold_seg", 32'(seg_data), 32'hFF00);
        end
        reset = 1'b1;
    endtask

    // which: 0 = mode, 1 = go, 2 = both together.
    task automatic press_btn(input int which, input int hi, input int lo);
        if (which == 0) btn_mode = 1'b1;
        else if (which == 1) btn_go = 1'b1;
        else begin btn_mode = 1'b1; btn_go = 1'b1; end
        repeat (hi) cycle();
        btn_mode = 1'b0;
        btn_go = 1'b0;
        repeat (lo) cycle();
    endtask

    int g0;

    initial begin
        model_reset();
        mode_led = 64'h4444_3333_2222_1111;
        mode_seg = 64'hD444_C333_B222_A111;
        @(negedge clk);
        do_reset(2);
        repeat (4) cycle();

        // Mode cycling in IDLE.
        press_btn(0, 6, 6);
        press_btn(0, 6, 6);
        press_btn(0, 6, 6);
        chk("s1_mode3", 32'(cur_mode), 32'd3);
        chk("s1_seg3", 32'(seg_data), 32'hFF03);
        press_btn(0, 6, 6);
        chk("s1_wrap", 32'(cur_mode), 32'd0);
        chk("s1_inactive", 32'(active), 32'd0);

        // Start mode 2.
        press_btn(0, 6, 6);
        press_btn(0, 6, 6);
        press_btn(1, 6, 6);
        chk("s2_active", 32'(active), 32'b0100);
        chk("s2_led", 32'(led), 32'h3333);
        chk("s2_seg", 32'(seg_data), 32'hC333);

        // Go strobe in RUN.
        g0 = go_count;
        press_btn(1, 6, 6);
        chk("s3_go_count", 32'(go_count - g0), 32'd1);
        chk("s3_go_bit", 32'(last_go), 32'b0100);

        // Mode switches in RUN: 2 -> 3 -> 0 (wrap).
        press_btn(0, 6, 8);
        chk("s4_active3", 32'(active), 32'b1000);
        press_btn(0, 6, 8);
        chk("s4_mode0", 32'(cur_mode), 32'd0);
        chk("s4_active0", 32'(active), 32'b0001);

        // Glitch, then simultaneous presses in RUN.
        g0 = go_count;
        press_btn(1, 2, 8);
        chk("s5_glitch_go", 32'(go_count - g0), 32'd0);
        press_btn(2, 6, 8);
        chk("s5_both_mode", 32'(cur_mode), 32'd1);
        chk("s5_both_go", 32'(go_count - g0), 32'd0);

        // Reset mid-GUARD with the mode button held through release.
        btn_mode = 1'b1;
        repeat (7) cycle();
        do_reset(3);
        repeat (10) cycle();
        chk("s6_held_mode", 32'(cur_mode), 32'd0);
        btn_mode = 1'b0;
        repeat (8) cycle();
        press_btn(0, 6, 6);
        chk("s6_repress", 32'(cur_mode), 32'd1);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 5) == 0) btn_go = ~btn_go;
            mode_led = {$urandom(), $urandom()};
            mode_seg = {$urandom(), $urandom()};
            if ($urandom_range(0, 499) == 0) do_reset(2);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
